mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
// - MEM stage; sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
// - Runs RV32I loads/stores over the shared byte-wide RAM port, one byte per granted cycle.
// - Requests a pipeline stall until the access completes. Non-memory ops pass straight through.
// PARAMETERS
// - ADDR_W  32  RAM byte-address width; matches `RamAddrBus
// - ALUOP_W  8  aluop width; matches `AluOpBus
// PORTS
// - clk  in  1  clock, rising edge
// - rst  in  1  asynchronous, active-high reset
// - wd_i / wreg_i / wdata_i  in  5/1/32  dest reg, write enable, ALU result from EX/MEM
// - mem_addr_i  in  ADDR_W  effective byte address
// - mem_write_data_i  in  32  store data
// - mem_rw_i  in  1  0 = load, 1 = store; valid only for load/store aluops
// - aluop_i  in  ALUOP_W  EXE_{LB,LH,LW,LBU,LHU,SB,SH,SW}_OP select an access; any other code is pass-through
// - pipe_adv_i  in  1  EX/MEM captures a new instruction at this edge
// - ram_req_o / ram_rw_o  out  1/1  byte request; 1 = write
// - ram_addr_o  out  ADDR_W  byte address
// - ram_wdata_o  out  8  write byte
// - ram_gnt_i  in  1  arbiter grants the request at this edge
// - ram_rdata_i  in  8  read byte, valid the cycle after its grant
// - wd_o / wreg_o / wdata_o  out  5/1/32  result to MEM/WB
// - stall_req_o  out  1  stall request to the halt controller
// - misalign_o  out  1  misaligned access flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state IDLE; counter, latches and result cleared; ram_req_o 0.
// - Pass-through ops (with a NOP input this gives all-zero outputs):
//   - wd_o/wreg_o/wdata_o = inputs, combinationally.
//   - stall_req_o 0, ram_req_o 0, state stays IDLE.
// - Access size N = 1 (B/BU/SB), 2 (H/HU/SH), 4 (W/SW). Little-endian; byte k is at mem_addr_i+k.
// - stall_req_o = (access op present) && state != DONE.
// - IDLE, access op present: at the edge, latch addr/data/N/sign/rw, clear cnt, go to BUSY.
// - BUSY: ram_req_o = 1; ram_addr_o = base+cnt; ram_wdata_o = store byte cnt.
//   - Edge with ram_gnt_i: cnt++. The grant of byte N-1 sends stores to DONE and loads to TAIL.
//   - No grant: hold all RAM outputs stable.
// - Loads, byte capture: ram_rdata_i is captured into byte (cnt-1) on the cycle after each grant.
//   - This overlaps with issuing the next byte, so continuous grants need no bubbles.
// - TAIL: capture the last byte; sign-extend (LB/LH) or zero-extend (LBU/LHU); go to DONE.
// - DONE outputs: wd_o = latched dest; wreg_o = latched wreg_i; wdata_o = load result (loads) or 0 (stores).
// - DONE exit: hold outputs until pipe_adv_i, then go to IDLE at that edge.
//   - This blocks re-issue while EX/MEM holds the same op under an unrelated stall.
// - Latency, continuous grant: LW/LH/LB take 6/4/3 cycles from IDLE to DONE; SW/SH/SB take 5/3/2.
// - Withheld grant stretches BUSY with no upper bound. No byte is lost or duplicated.
// - Address wraps modulo 2^ADDR_W.
// - Mid-operation reset: ram_req_o drops immediately and the partial access is abandoned.
//   - Store bytes already granted stay written.
// - Inputs changing while BUSY/TAIL/DONE are ignored (latched copy is used).
// CONFIGURATION
// - MEM_MISALIGN_CHECK_EN defined:
//   - Flagged accesses: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0.
//   - For these: no RAM request; misalign_o = 1 combinationally; wreg_o forced 0; stall_req_o 0; state stays IDLE.
// - MEM_MISALIGN_CHECK_EN undefined: misaligned accesses run byte-wise as normal; misalign_o tied 0.
// TESTING
// - Reset mid-BUSY of an SW -> ram_req_o 0 at once, state IDLE, stall_req_o 0 after release.
// - LW 0x100, gnt always 1, RAM 0x100..0x103 = 78 56 34 12 -> wdata_o 0x12345678, stall high 6 cycles.
// - LB/LBU 0x200 holding 0x80 -> wdata_o 0xFFFFFF80 / 0x00000080.
// - SH 0x0FF data 0xABCD, gnt toggled 1,0,0,1 -> writes CD@0x0FF then AB@0x100; addr/wdata held while gnt=0.
// - DONE held 3 cycles with pipe_adv_i 0 -> no new ram_req_o; advance -> IDLE; next ADD passes through with stall 0.
// - MEM_MISALIGN_CHECK_EN: LW 0x102 -> misalign_o 1, wreg_o 0, no ram_req_o; undefined -> bytes 0x102..0x105 read.

Source files
------------

// File: rtl/mem_access_if.sv
// Byte-wide shared RAM port between the MEM stage (master) and the RAM arbiter (slave).
interface mem_access_if #(
    parameter int ADDR_W = 32
);
    logic              ram_req_o;
    logic              ram_rw_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [7:0]        ram_wdata_o;
    logic              ram_gnt_i;
    logic [7:0]        ram_rdata_i;

    modport master (
        output ram_req_o, ram_rw_o, ram_addr_o, ram_wdata_o,
        input  ram_gnt_i, ram_rdata_i
    );

    modport slave (
        input  ram_req_o, ram_rw_o, ram_addr_o, ram_wdata_o,
        output ram_gnt_i, ram_rdata_i
    );
endinterface

// File: rtl/mem_access.sv
// MEM stage: RV32I loads/stores issued one byte per granted cycle over a shared RAM port.
// Optional MEM_MISALIGN_CHECK_EN flags misaligned H/W accesses instead of running them.
module mem_access #(
    parameter int ADDR_W  = 32,
    parameter int ALUOP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         wd_i,
    input  logic               wreg_i,
    input  logic [31:0]        wdata_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [31:0]        mem_write_data_i,
    input  logic               mem_rw_i,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic               pipe_adv_i,
    mem_access_if.master       ram,
    output logic [4:0]         wd_o,
    output logic               wreg_o,
    output logic [31:0]        wdata_o,
    output logic               stall_req_o,
    output logic               misalign_o
);
    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = ALUOP_W'('hE0);
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = ALUOP_W'('hE1);
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = ALUOP_W'('hE3);
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = ALUOP_W'('hE4);
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = ALUOP_W'('hE5);
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = ALUOP_W'('hE8);
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = ALUOP_W'('hE9);
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = ALUOP_W'('hEB);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        r_state;
    logic [2:0]        r_cnt;
    logic [2:0]        r_size;
    logic              r_sign;
    logic              r_rw;
    logic              r_cap;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_sdata;
    logic [31:0]       r_data;
    logic [4:0]        r_wd;
    logic              r_wreg;

    logic        w_acc;
    logic        w_mis;
    logic        w_go;
    logic        w_last;
    logic [2:0]  w_size;
    logic        w_sign;
    logic [4:0]  w_bidx;
    logic [4:0]  w_widx;
    logic [31:0] w_raw;
    logic [31:0] w_ext;

    always_comb begin
        w_acc  = 1'b1;
        w_size = 3'd1;
        w_sign = 1'b0;
        case (aluop_i)
            EXE_LB_OP:  w_sign = 1'b1;
            EXE_LBU_OP: w_size = 3'd1;
            EXE_LH_OP: begin
                w_size = 3'd2;
                w_sign = 1'b1;
            end
            EXE_LHU_OP: w_size = 3'd2;
            EXE_LW_OP:  w_size = 3'd4;
            EXE_SB_OP:  w_size = 3'd1;
            EXE_SH_OP:  w_size = 3'd2;
            EXE_SW_OP:  w_size = 3'd4;
            default:    w_acc  = 1'b0;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_mis = w_acc &&
                   ((w_size == 3'd2 && mem_addr_i[0]) ||
                    (w_size == 3'd4 && mem_addr_i[1:0] != 2'b00));
`else
    assign w_mis = 1'b0;
`endif

    assign w_go   = (r_state == IDLE) && w_acc && !w_mis;
    assign w_last = (r_cnt == r_size - 3'd1);
    // Byte granted on the previous cycle sits at cnt-1 (wraps 0 -> 3 for the 4th byte).
    assign w_bidx = {r_cnt[1:0] - 2'd1, 3'b000};
    assign w_widx = {r_cnt[1:0], 3'b000};

    always_comb begin
        w_raw = r_data;
        w_raw[w_bidx +: 8] = ram.ram_rdata_i;
        case (r_size)
            3'd1:    w_ext = {{24{r_sign & w_raw[7]}}, w_raw[7:0]};
            3'd2:    w_ext = {{16{r_sign & w_raw[15]}}, w_raw[15:0]};
            default: w_ext = w_raw;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_size  <= 3'd0;
            r_sign  <= 1'b0;
            r_rw    <= 1'b0;
            r_cap   <= 1'b0;
            r_addr  <= '0;
            r_sdata <= 32'd0;
            r_data  <= 32'd0;
            r_wd    <= 5'd0;
            r_wreg  <= 1'b0;
        end else begin
            r_cap <= (r_state == BUSY) && ram.ram_gnt_i && !r_rw;
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_addr  <= mem_addr_i;
                        r_sdata <= mem_write_data_i;
                        r_size  <= w_size;
                        r_sign  <= w_sign;
                        r_rw    <= mem_rw_i;
                        r_wd    <= wd_i;
                        r_wreg  <= wreg_i;
                        r_cnt   <= 3'd0;
                        r_data  <= 32'd0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cap) r_data <= w_raw;
                    if (ram.ram_gnt_i) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (w_last) r_state <= r_rw ? DONE : TAIL;
                    end
                end
                TAIL: begin
                    r_data  <= w_ext;
                    r_state <= DONE;
                end
                default: begin
                    if (pipe_adv_i) r_state <= IDLE;
                end
            endcase
        end
    end

    assign ram.ram_req_o   = (r_state == BUSY);
    assign ram.ram_rw_o    = r_rw;
    assign ram.ram_addr_o  = r_addr + ADDR_W'(r_cnt);
    assign ram.ram_wdata_o = r_sdata[w_widx +: 8];

    assign stall_req_o = w_go || (r_state == BUSY) || (r_state == TAIL);
    assign misalign_o  = (r_state == IDLE) && w_mis;

    always_comb begin
        wd_o    = wd_i;
        wreg_o  = wreg_i;
        wdata_o = wdata_i;
        if (r_state == DONE) begin
            wd_o    = r_wd;
            wreg_o  = r_wreg;
            wdata_o = r_rw ? 32'd0 : r_data;
        end else if (r_state != IDLE || w_acc) begin
            wreg_o = 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: vector table, hand-written corner sequences and random ops vs a byte-map model.
module tb_mem_access;
    localparam logic [7:0] LB  = 8'hE0;
    localparam logic [7:0] LH  = 8'hE1;
    localparam logic [7:0] LW  = 8'hE3;
    localparam logic [7:0] LBU = 8'hE4;
    localparam logic [7:0] LHU = 8'hE5;
    localparam logic [7:0] SB  = 8'hE8;
    localparam logic [7:0] SH  = 8'hE9;
    localparam logic [7:0] SW  = 8'hEB;
    localparam logic [7:0] ADD = 8'h20;
    localparam logic [7:0] NOP = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] mem_write_data_i = 32'd0;
    logic        mem_rw_i = 1'b0;
    logic [7:0]  aluop_i = NOP;
    logic        pipe_adv_i = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req_o;
    logic        misalign_o;

    mem_access_if #(.ADDR_W(32)) bus ();

    mem_access #(.ADDR_W(32), .ALUOP_W(8)) dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem_addr_i(mem_addr_i), .mem_write_data_i(mem_write_data_i),
        .mem_rw_i(mem_rw_i), .aluop_i(aluop_i), .pipe_adv_i(pipe_adv_i),
        .ram(bus),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stall_req_o(stall_req_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM behind the arbiter, plus the model's view of what memory should hold
    logic [7:0]  mem     [bit [31:0]];
    logic [7:0]  ref_mem [bit [31:0]];
    logic [39:0] wlog    [$];
    bit          gq      [$];
    bit          gmode = 1'b0;

    function automatic logic [7:0] rd_mem(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rd_ref(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic poke(input bit [31:0] a, input logic [7:0] b);
        mem[a]     = b;
        ref_mem[a] = b;
    endtask

    initial bus.ram_rdata_i = 8'h00;

    always @(posedge clk) begin
        if (bus.ram_req_o && bus.ram_gnt_i) begin
            if (bus.ram_rw_o) begin
                mem[bus.ram_addr_o] = bus.ram_wdata_o;
                wlog.push_back({bus.ram_addr_o, bus.ram_wdata_o});
            end else begin
                bus.ram_rdata_i <= rd_mem(bus.ram_addr_o);
            end
        end
    end

    // Grant driver; also checks the request stays frozen across a withheld grant
    logic        p_req = 1'b0;
    logic        p_gnt = 1'b1;
    logic [40:0] p_bus = '0;
    always @(negedge clk) begin
        if (bus.ram_req_o && p_req && !p_gnt)
            chk("hold", {bus.ram_addr_o, bus.ram_wdata_o, bus.ram_rw_o}, p_bus);
        if (bus.ram_req_o && gq.size() > 0)
            bus.ram_gnt_i = gq.pop_front();
        else if (gmode)
            bus.ram_gnt_i = 1'($urandom_range(0, 1));
        else
            bus.ram_gnt_i = 1'b1;
        p_req = bus.ram_req_o;
        p_gnt = bus.ram_gnt_i;
        p_bus = {bus.ram_addr_o, bus.ram_wdata_o, bus.ram_rw_o};
    end

    function automatic int op_size(input logic [7:0] op);
        if (op == LW || op == SW) return 4;
        if (op == LH || op == LHU || op == SH) return 2;
        return 1;
    endfunction

    function automatic bit op_store(input logic [7:0] op);
        return op == SB || op == SH || op == SW;
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input bit [31:0] a);
        int n = op_size(op);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(rd_ref(a + k)) << (8 * k));
        if (op == LB && v[7])  v = v | 32'hFFFF_FF00;
        if (op == LH && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic start_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                            input logic [4:0] wd, input logic wr, output int cyc);
        aluop_i = op;
        mem_addr_i = a;
        mem_write_data_i = d;
        mem_rw_i = op_store(op);
        wd_i = wd;
        wreg_i = wr;
        wdata_i = $urandom;
        pipe_adv_i = 1'b0;
        #1;
        cyc = 0;
        while (stall_req_o && cyc <= 400) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic finish_op();
        pipe_adv_i = 1'b1;
        @(negedge clk);
        pipe_adv_i = 1'b0;
        aluop_i = NOP;
        mem_rw_i = 1'b0;
        wd_i = 5'd0;
        wreg_i = 1'b0;
        wdata_i = 32'd0;
        #1;
    endtask

    task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] wd, input logic wr,
                         input int exp_lat, input logic [31:0] exp_w);
        int cyc;
        int n = op_size(op);
        logic [31:0] am, ar;
        start_op(op, a, d, wd, wr, cyc);
        chk("timeout", 64'(cyc > 400), 64'd0);
        if (exp_lat >= 0) chk("latency", 64'(cyc), 64'(exp_lat));
        chk("wdata_o", wdata_o, exp_w);
        chk("wd_o", wd_o, wd);
        chk("wreg_o", wreg_o, wr);
        if (op_store(op)) begin
            for (int k = 0; k < n; k++) ref_mem[a + k] = d[8*k +: 8];
            am = 32'd0;
            ar = 32'd0;
            for (int k = 0; k < n; k++) begin
                am[8*k +: 8] = rd_mem(a + k);
                ar[8*k +: 8] = rd_ref(a + k);
            end
            chk("store_mem", am, ar);
        end
        finish_op();
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] exp_w;
        int          exp_lat;
    } vec_t;

    vec_t vq[$];

    initial begin
        int cyc;
        logic [31:0] a, d, e;
        logic [7:0]  op;
        logic [7:0]  ops [8];

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", bus.ram_req_o, 1'b0);
        chk("rst_stall", stall_req_o, 1'b0);
        chk("rst_out", {wd_o, wreg_o, wdata_o, misalign_o}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_out", {wd_o, wreg_o, wdata_o, stall_req_o, bus.ram_req_o}, '0);

        poke(32'h100, 8'h78); poke(32'h101, 8'h56);
        poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        poke(32'h200, 8'h80);
        poke(32'h300, 8'h34); poke(32'h301, 8'h92);

        vq.push_back('{LW,  32'h100, 32'h0,        32'h1234_5678, 6});
        vq.push_back('{LB,  32'h200, 32'h0,        32'hFFFF_FF80, 3});
        vq.push_back('{LBU, 32'h200, 32'h0,        32'h0000_0080, 3});
        vq.push_back('{LH,  32'h300, 32'h0,        32'hFFFF_9234, 4});
        vq.push_back('{LHU, 32'h300, 32'h0,        32'h0000_9234, 4});
        vq.push_back('{SW,  32'h400, 32'hDEAD_BEEF, 32'h0,        5});
        vq.push_back('{SB,  32'h500, 32'h1122_3344, 32'h0,        2});
        vq.push_back('{SH,  32'h600, 32'h5566_AABB, 32'h0,        3});
        vq.push_back('{LW,  32'h400, 32'h0,        32'hDEAD_BEEF, 6});
        vq.push_back('{LB,  32'h403, 32'h0,        32'hFFFF_FFDE, 3});
        vq.push_back('{LBU, 32'h500, 32'h0,        32'h0000_0044, 3});
        vq.push_back('{LH,  32'h600, 32'h0,        32'hFFFF_AABB, 4});
`ifndef MEM_MISALIGN_CHECK_EN
        vq.push_back('{SW,  32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0, 5});
        vq.push_back('{LW,  32'hFFFF_FFFE, 32'h0, 32'hCAFE_F00D, 6});
        vq.push_back('{LHU, 32'h0000_0000, 32'h0, 32'h0000_CAFE, 4});
`endif
        foreach (vq[i])
            do_op(vq[i].op, vq[i].addr, vq[i].sdata, 5'(i + 1), ~op_store(vq[i].op),
                  vq[i].exp_lat, vq[i].exp_w);

        // DONE held without pipe advance, then a pass-through ADD
        start_op(LW, 32'h100, 32'h0, 5'd9, 1'b1, cyc);
        chk("hold_lat", 64'(cyc), 64'd6);
        aluop_i = SW;
        mem_addr_i = 32'h700;
        mem_rw_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("done_noreq", {bus.ram_req_o, stall_req_o}, 2'b00);
            chk("done_wdata", {wd_o, wreg_o, wdata_o}, {5'd9, 1'b1, 32'h1234_5678});
        end
        finish_op();
        aluop_i = ADD;
        wd_i = 5'd3;
        wreg_i = 1'b1;
        wdata_i = 32'h0000_0055;
        #1;
        chk("add_pass", {wd_o, wreg_o, wdata_o, stall_req_o}, {5'd3, 1'b1, 32'h55, 1'b0});
        @(negedge clk);
        chk("add_noreq", {bus.ram_req_o, stall_req_o, wdata_o}, {1'b0, 1'b0, 32'h55});
        aluop_i = NOP;
        wreg_i = 1'b0;
        wdata_i = 32'd0;
        wd_i = 5'd0;

        // SH with the grant withheld twice mid-access
`ifdef MEM_MISALIGN_CHECK_EN
        a = 32'h0FE;
`else
        a = 32'h0FF;
`endif
        wlog.delete();
        gq = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_op(SH, a, 32'h0000_ABCD, 5'd4, 1'b0, 5, 32'h0);
        chk("sh_nwrites", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("sh_w0", wlog[0], {a, 8'hCD});
            chk("sh_w1", wlog[1], {a + 32'd1, 8'hAB});
        end
        gq.delete();

        // Misaligned word load
`ifdef MEM_MISALIGN_CHECK_EN
        aluop_i = LW;
        mem_addr_i = 32'h102;
        mem_rw_i = 1'b0;
        wd_i = 5'd6;
        wreg_i = 1'b1;
        #1;
        chk("mis_flag", {misalign_o, wreg_o, stall_req_o, bus.ram_req_o}, 4'b1000);
        @(negedge clk);
        chk("mis_idle", {misalign_o, stall_req_o, bus.ram_req_o}, 3'b100);
        aluop_i = NOP;
        wreg_i = 1'b0;
        #1;
        chk("mis_clear", misalign_o, 1'b0);
`else
        e = model_load(LW, 32'h102);
        aluop_i = LW;
        mem_addr_i = 32'h102;
        #1;
        chk("mis_off", misalign_o, 1'b0);
        do_op(LW, 32'h102, 32'h0, 5'd6, 1'b1, 6, e);
`endif

        // Random ops against the byte-map model
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 7)];
            a = 32'h1000 + 32'($urandom_range(0, 255));
`ifdef MEM_MISALIGN_CHECK_EN
            a = a & ~(32'(op_size(op)) - 32'd1);
`endif
            d = $urandom;
            gmode = 1'($urandom_range(0, 1));
            e = op_store(op) ? 32'h0 : model_load(op, a);
            do_op(op, a, d, 5'($urandom), 1'($urandom), 
                  gmode ? -1 : op_size(op) + (op_store(op) ? 1 : 2), e);
        end
        gmode = 1'b0;

        // Reset in the middle of a store
        aluop_i = SW;
        mem_addr_i = 32'h900;
        mem_write_data_i = 32'h0102_0304;
        mem_rw_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_busy", bus.ram_req_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", bus.ram_req_o, 1'b0);
        aluop_i = NOP;
        mem_rw_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_stall", stall_req_o, 1'b0);
        @(negedge clk);
        chk("mid_rel_req", {bus.ram_req_o, stall_req_o}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
